uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO, the next generation of the `uart_top` TX path. Runtime-configurable frame format: 5–8 data bits, optional odd/even parity, 1 or 2 stop bits, and a programmable bit-period divisor. Upstream logic pushes bytes through a write handshake. The block serialises them back-to-back onto `tx` with no idle gap while the FIFO holds data. It sits between the host/bus side and the UART pin, and pairs with the existing RX path.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a DEPTH-entry FIFO; define UART_TX_BREAK_EN to add break_req and the BREAK state
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic [3:0]               length,
  input  logic                     parity_en,
  input  logic                     parity_type,
  input  logic                     stop2,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
`ifdef UART_TX_BREAK_EN
  input  logic                     break_req,
`endif
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     wr_err,
  output logic                     tx,
  output logic                     tx_busy,
  output logic                     tx_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [DIV_W-1:0] DIV_ONE = 1;
  localparam logic [DIV_W-1:0] DIV_MIN = 4;
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
`ifdef UART_TX_BREAK_EN
    , BRK
`endif
  } state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic push, pop, brk, tick, last_stop, par_bit, par_en_s, stop2_s;
  logic [DIV_W-1:0] div_eff, div_s, div_cnt;
  logic [3:0] len_eff, len_s;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, head, masked;
`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif
  always_comb begin
    div_eff = baud_div < DIV_MIN ? DIV_MIN : baud_div;
    len_eff = length < 4'd5 ? 4'd5 : length > 4'd8 ? 4'd8 : length;
    head = mem[rptr[AW-1:0]];
    masked = head & (8'hFF >> (4'd8 - len_eff));
    tick = div_cnt == div_s - DIV_ONE;
    last_stop = tick && ((state == STOP1 && !stop2_s) || state == STOP2);
    push = wr_en && !full;
    pop = !empty && !brk && (state == IDLE || last_stop);
    wptr_n = push ? wptr + PTR_ONE : wptr;
    rptr_n = pop ? rptr + PTR_ONE : rptr;
  end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      level <= '0;
      wr_err <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      empty <= wptr_n == rptr_n;
      full <= (wptr_n ^ rptr_n) == PTR_MSB;
      level <= wptr_n - rptr_n;
      wr_err <= wr_en && full;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      div_cnt <= '0;
      div_s <= DIV_MIN;
      len_s <= 4'd8;
      par_en_s <= 1'b0;
      stop2_s <= 1'b0;
      par_bit <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
    end else begin
      tx_done <= last_stop;
      if (pop) begin
        state <= START;
        tx <= 1'b0;
        tx_busy <= 1'b1;
        div_cnt <= '0;
        shreg <= head;
        div_s <= div_eff;
        len_s <= len_eff;
        par_en_s <= parity_en;
        stop2_s <= stop2;
        par_bit <= parity_type ? ^masked : ~^masked;
      end else if (state == IDLE) begin
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          state <= BRK;
          tx <= 1'b0;
        end
`endif
      end
`ifdef UART_TX_BREAK_EN
      else if (state == BRK) begin
        if (!brk) begin
          state <= IDLE;
          tx <= 1'b1;
        end
      end
`endif
      else if (!tick) div_cnt <= div_cnt + DIV_ONE;
      else begin
        div_cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            tx <= shreg[0];
            shreg <= shreg >> 1;
            bit_cnt <= '0;
          end
          DATA:
            if ({1'b0, bit_cnt} == len_s - 4'd1) begin
              state <= par_en_s ? PARITY : STOP1;
              tx <= par_en_s ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx <= shreg[0];
              shreg <= shreg >> 1;
            end
          PARITY: begin
            state <= STOP1;
            tx <= 1'b1;
          end
          STOP1:
            if (stop2_s) state <= STOP2;
            else begin
              state <= IDLE;
              tx_busy <= 1'b0;
            end
          default: begin
            state <= IDLE;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
endmodule
